// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-side hazard unit. Keeps a small down-counter per architectural
//   register holding the number of cycles until that register's pending
//   result can be bypassed. Raises stall when the instruction in decode
//   reads a still-pending register (RAW), or would overwrite a register
//   whose older result completes later than its own (WAW).
//
// Ports
//   clk          CPU clock, rising edge
//   rst_n        synchronous reset, active low
//   en           pipeline advance (0 = freeze: all state holds)
//   flush        squash the instruction in decode (forces stall=0)
//   issue_valid  decode holds a valid instruction
//   rs_addr      NRP source addresses, port p = [p*AW +: AW]
//   rs_en        per-port "this port really reads" qualifier
//   rd_addr      destination register
//   rd_we        instruction writes rd
//   rd_lat       cycles until the result is bypassable (0 = forwardable now)
//   stall        hold PC/IF/ID and inject a bubble into EX
//   busy         bit r set while register r has a pending result
//   stall_count  saturating count of advancing cycles spent stalled
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = $clog2(NREG),
  parameter int NRP     = 2,
  parameter int LAT_MAX = 7,
  parameter int CW      = $clog2(LAT_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [NRP*AW-1:0] rs_addr,
  input  logic [NRP-1:0]    rs_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic              rd_we,
  input  logic [CW-1:0]     rd_lat,
  output logic              stall,
  output logic [NREG-1:0]   busy,
  output logic [31:0]       stall_count
);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic [31:0]   stall_count_q;
  logic [31:0]   stall_count_d;

  logic          raw;
  logic          waw;
  logic          rd_hit;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] lat_cl;
  logic          stall_c;
  logic          fire;

  // Hazard detection. Lookups compare against every tracked index rather
  // than indexing directly, so x0 and addresses >= NREG never match.
  always_comb begin
    raw = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      for (int r = 1; r < NREG; r++) begin
        if (rs_en[p] && (rs_addr[p*AW +: AW] == AW'(r)) && (cnt_q[r] != '0))
          raw = 1'b1;
      end
    end

    rd_hit = 1'b0;
    rd_cnt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (rd_addr == AW'(r)) begin
        rd_hit = 1'b1;
        rd_cnt = cnt_q[r];
      end
    end

    lat_cl = (int'(rd_lat) > LAT_MAX) ? CW'(LAT_MAX) : rd_lat;

    // An older result landing after ours would clobber it; wait until the
    // older one completes no later than the new one.
    waw     = rd_we && rd_hit && (rd_cnt > lat_cl);
    stall_c = issue_valid && !flush && (raw || waw);
    fire    = en && issue_valid && !stall_c && !flush && rd_we && rd_hit;
  end

  // Next-state: decrement every pending counter; a new allocation on the
  // same register overrides its decrement. Freeze holds everything.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0 && en) begin
        if (fire && (rd_addr == AW'(r)))
          cnt_d[r] = lat_cl;
        else if (cnt_q[r] != '0)
          cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
    cnt_d[0] = '0;

    stall_count_d = stall_count_q;
    if (en && stall_c && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      stall_count_q <= stall_count_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy[gi] = 1'b0;
      end else begin : g_reg
        assign busy[gi] = (cnt_q[gi] != '0);
      end
    end
  endgenerate

  assign stall       = stall_c;
  assign stall_count = stall_count_q;

endmodule
